// File: rtl/mic_pdm_capture_if.sv
// Signal bundle between the PDM capture block and its PLL/mic/filter neighbours.
// master is the capture block; slave is the environment that drives lock and data.
interface mic_pdm_capture_if #(
    parameter int NUM_LINES = 4
);
    logic                 pll_lock;
    logic [NUM_LINES-1:0] mic_data;
    logic                 mic_clk;
    logic [NUM_LINES-1:0] pdm_left;
    logic [NUM_LINES-1:0] pdm_right;
    logic                 pdm_valid;
    logic                 running;

    modport master (
        input  pll_lock,
        input  mic_data,
        output mic_clk,
        output pdm_left,
        output pdm_right,
        output pdm_valid,
        output running
    );

    modport slave (
        output pll_lock,
        output mic_data,
        input  mic_clk,
        input  pdm_left,
        input  pdm_right,
        input  pdm_valid,
        input  running
    );
endinterface

// File: rtl/mic_pdm_capture.sv
// Qualifies PLL lock, drives the PDM bit clock and captures one
// left/right bit pair per line per mic clock period.
module mic_pdm_capture #(
    parameter int NUM_LINES   = 4,
    parameter int CLK_DIV     = 20,
    parameter int LOCK_STABLE = 1024
) (
    input  logic                  clkin,
    input  logic                  reset,
    mic_pdm_capture_if.master     bus
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = $clog2(CLK_DIV);
    localparam int SW   = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HIGH_LAST = DW'(HALF - 1);
    localparam logic [DW-1:0] HALF_V    = DW'(HALF);
    localparam logic [SW-1:0] SET_LAST  = SW'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } state_t;

    state_t               state;
    logic                 lock_s1;
    logic                 lock_s;
    logic [NUM_LINES-1:0] data_s1;
    logic [NUM_LINES-1:0] data_s;
    logic [SW-1:0]        settle_cnt;
    logic [DW-1:0]        div_cnt;
    logic [DW-1:0]        div_next;
    logic [NUM_LINES-1:0] left_hold;
    logic [NUM_LINES-1:0] right_hold;
    logic                 pair_pend;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
            data_s1 <= '0;
            data_s  <= '0;
        end else begin
            lock_s1 <= bus.pll_lock;
            lock_s  <= lock_s1;
            data_s1 <= bus.mic_data;
            data_s  <= data_s1;
        end
    end

    always_comb begin
        div_next = div_cnt + 1'b1;
        if (div_cnt == DIV_LAST) div_next = '0;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            div_cnt       <= '0;
            left_hold     <= '0;
            right_hold    <= '0;
            pair_pend     <= 1'b0;
            bus.mic_clk   <= 1'b0;
            bus.pdm_left  <= '0;
            bus.pdm_right <= '0;
            bus.pdm_valid <= 1'b0;
            bus.running   <= 1'b0;
        end else begin
            bus.pdm_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.mic_clk <= 1'b0;
                    bus.running <= 1'b0;
                    pair_pend   <= 1'b0;
                    settle_cnt  <= '0;
                    if (lock_s) state <= SETTLE;
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SET_LAST) begin
                        state       <= RUN;
                        settle_cnt  <= '0;
                        div_cnt     <= '0;
                        bus.running <= 1'b1;
                        bus.mic_clk <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        // pending or half-built pair dies with the lock
                        state       <= IDLE;
                        div_cnt     <= '0;
                        pair_pend   <= 1'b0;
                        bus.mic_clk <= 1'b0;
                        bus.running <= 1'b0;
                    end else begin
                        div_cnt     <= div_next;
                        bus.mic_clk <= (div_next < HALF_V);
                        if (div_cnt == HIGH_LAST) left_hold <= data_s;
                        if (div_cnt == DIV_LAST) begin
                            right_hold <= data_s;
                            pair_pend  <= 1'b1;
                        end else begin
                            pair_pend  <= 1'b0;
                        end
                        if (pair_pend) begin
                            bus.pdm_left  <= left_hold;
                            bus.pdm_right <= right_hold;
                            bus.pdm_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mic_clk <= 1'b0;
                    bus.running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mic_pdm_capture.sv
// Randomized bench for mic_pdm_capture against a lock-streak reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_mic_pdm_capture;
    localparam int NL   = 4;
    localparam int CD   = 20;
    localparam int LS   = 1024;
    localparam int HALF = CD / 2;

    logic clkin = 1'b0;
    logic reset = 1'b1;

    mic_pdm_capture_if #(.NUM_LINES(NL)) bus ();

    mic_pdm_capture #(
        .NUM_LINES  (NL),
        .CLK_DIV    (CD),
        .LOCK_STABLE(LS)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: lock is seen two edges late; RUN holds once the
    // seen lock has been high for LS+1 consecutive edges.
    bit          lk1, lk2;
    int          streak;
    int          p;
    logic [NL-1:0] hist [0:15];
    logic        e_clk, e_run, e_valid;
    logic [NL-1:0] e_left, e_right;

    initial begin
        lk1 = 0; lk2 = 0; streak = 0;
        e_clk = 0; e_run = 0; e_valid = 0; e_left = '0; e_right = '0;
        for (int k = 0; k < 16; k++) hist[k] = '0;
        forever begin
            @(posedge clkin);
            if (reset) begin
                lk1 = 0; lk2 = 0; streak = 0;
                e_clk = 0; e_run = 0; e_valid = 0; e_left = '0; e_right = '0;
                for (int k = 0; k < 16; k++) hist[k] = '0;
            end else begin
                for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = bus.mic_data;
                streak = lk2 ? streak + 1 : 0;
                lk2 = lk1;
                lk1 = bus.pll_lock;
                e_run = (streak >= LS + 1);
                p = streak - LS - 1;
                e_clk = e_run && ((p % CD) < HALF);
                e_valid = e_run && (p >= CD + 1) && (((p - 1) % CD) == 0);
                if (e_valid) begin
                    e_left  = hist[13];
                    e_right = hist[3];
                end
            end
        end
    end

    bit pat_mode = 0;
    int pat_cnt  = 0;
    int cyc      = 0;
    int last_v   = -1;

    initial begin
        bus.mic_data = '0;
        forever begin
            @(negedge clkin);
            if (pat_mode)
                bus.mic_data = {~bus.mic_clk, 1'b0, 1'b0, bus.mic_clk};
            else
                bus.mic_data = NL'($urandom);
        end
    end

    initial begin
        forever begin
            @(negedge clkin);
            cyc++;
            if (reset) begin
                check("reset_outs", {bus.mic_clk, bus.pdm_left, bus.pdm_right,
                                     bus.pdm_valid, bus.running}, 0);
            end else begin
                check("mic_clk",   bus.mic_clk,   e_clk);
                check("running",   bus.running,   e_run);
                check("pdm_valid", bus.pdm_valid, e_valid);
                check("pdm_left",  bus.pdm_left,  e_left);
                check("pdm_right", bus.pdm_right, e_right);
            end
            if (pat_mode) begin
                pat_cnt++;
                if (!reset && bus.pdm_valid && pat_cnt > 40) begin
                    check("pat_left",  bus.pdm_left,  4'b0001);
                    check("pat_right", bus.pdm_right, 4'b1000);
                    if (last_v >= 0) check("strobe_gap", cyc - last_v, CD);
                    last_v = cyc;
                end
            end else begin
                pat_cnt = 0;
                last_v  = -1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clkin);
    endtask

    initial begin
        int cnt;
        logic [NL-1:0] held_l, held_r;
        bus.pll_lock = 1'b1;
        cycles(5);
        reset = 1'b0;

        cnt = 0;
        while (!bus.running && cnt < 2000) begin
            @(posedge clkin);
            #1;
            cnt++;
        end
        check("lock_latency", (cnt >= 1025 && cnt <= 1027), 1);

        cycles(600);
        pat_mode = 1;
        cycles(2100);
        pat_mode = 0;
        cycles(40);

        for (int i = 0; i < 40 && bus.mic_clk; i++) @(negedge clkin);
        cycles(4);
        held_l = bus.pdm_left;
        held_r = bus.pdm_right;
        bus.pll_lock = 1'b0;
        cycles(4);
        check("loss_run", bus.running, 0);
        check("loss_clk", bus.mic_clk, 0);
        check("loss_hold", {bus.pdm_left, bus.pdm_right}, {held_l, held_r});
        cycles(16);

        bus.pll_lock = 1'b1;
        cycles(500);
        bus.pll_lock = 1'b0;
        cycles(10);
        bus.pll_lock = 1'b1;
        cycles(1000);
        check("settle_restart", bus.running, 0);
        cycles(300);

        for (int g = 0; g < 6; g++) begin
            cycles($urandom_range(50, 1500));
            bus.pll_lock = 1'b0;
            cycles($urandom_range(1, 3));
            bus.pll_lock = 1'b1;
        end
        cycles(1200);

        for (int i = 0; i < 1200 && !bus.running; i++) @(negedge clkin);
        cycles(37);
        @(posedge clkin);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", {bus.mic_clk, bus.pdm_left, bus.pdm_right,
                              bus.pdm_valid, bus.running}, 0);
        cycles(3);
        reset = 1'b0;
        cycles(1000);
        check("resettle_wait", bus.running, 0);
        cycles(100);
        check("resettle_run", bus.running, 1);
        cycles(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
